// File: rtl/mod_word_mem.sv
// Word memory with a registered-read streaming port: writes go straight into the
// array, while a start command streams a window of words out through a 2-deep skid buffer.
module mod_word_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 7,
    parameter int TOTAL_ADDR = 128
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_err,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic                  reverse,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done
);

    localparam int LW = ADDR_WIDTH + 1;
    localparam logic [LW-1:0]         LP_TOTAL_LEN  = LW'(TOTAL_ADDR);
    localparam logic [LW:0]           LP_TOTAL_MOD  = (LW + 1)'(TOTAL_ADDR);
    localparam logic [ADDR_WIDTH-1:0] LP_LAST_ADDR  = ADDR_WIDTH'(TOTAL_ADDR - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    logic [DATA_WIDTH-1:0] r_mem [TOTAL_ADDR];

    state_t                r_state;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_wr_err;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LW-1:0]         r_len;
    logic [LW-1:0]         r_issued;
    logic                  r_rev;
    logic                  r_rd_valid;
    logic                  r_rd_last;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic [DATA_WIDTH-1:0] r_buf0;
    logic [DATA_WIDTH-1:0] r_buf1;
    logic                  r_last0;
    logic                  r_last1;
    logic [1:0]            r_cnt;

    logic [LW-1:0]         w_len_clamp;
    logic [LW:0]           w_rev_sum;
    logic [ADDR_WIDTH-1:0] w_start_addr;
    logic [ADDR_WIDTH-1:0] w_next_addr;
    logic                  w_accept;
    logic [2:0]            w_pending;
    logic                  w_issue;
    logic                  w_final_issue;
    logic                  w_wr_ok;

    always_comb begin
        w_len_clamp   = (length > LP_TOTAL_LEN) ? LP_TOTAL_LEN : length;
        w_rev_sum     = (LW + 1)'(base_addr) + (LW + 1)'(w_len_clamp) - (LW + 1)'(1);
        w_start_addr  = reverse ? ADDR_WIDTH'(w_rev_sum % LP_TOTAL_MOD)
                                : ADDR_WIDTH'((LW + 1)'(base_addr) % LP_TOTAL_MOD);
        if (r_rev)
            w_next_addr = (r_addr == '0) ? LP_LAST_ADDR : r_addr - ADDR_WIDTH'(1);
        else
            w_next_addr = (r_addr == LP_LAST_ADDR) ? '0 : r_addr + ADDR_WIDTH'(1);
        w_accept      = (r_cnt != 2'd0) && out_ready;
        // Credit counts the slot freed by this cycle's acceptance so a steady stream has no bubbles.
        w_pending     = 3'(r_cnt) + 3'(r_rd_valid) - 3'(w_accept);
        w_issue       = (r_state == RUN) && (w_pending < 3'd2);
        w_final_issue = w_issue && (r_issued == r_len - LW'(1));
        w_wr_ok       = wr_en && !r_busy;
    end

    // Storage has no reset so its contents survive reset_n.
    always_ff @(posedge clock) begin
        if (w_wr_ok)
            r_mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_wr_err   <= 1'b0;
            r_addr     <= '0;
            r_len      <= '0;
            r_issued   <= '0;
            r_rev      <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
            r_rd_data  <= '0;
            r_buf0     <= '0;
            r_buf1     <= '0;
            r_last0    <= 1'b0;
            r_last1    <= 1'b0;
            r_cnt      <= 2'd0;
        end else begin
            r_done     <= 1'b0;
            r_rd_valid <= w_issue;
            r_rd_last  <= w_final_issue;

            if (wr_en && r_busy)
                r_wr_err <= 1'b1;

            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (length == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_addr   <= w_start_addr;
                            r_len    <= w_len_clamp;
                            r_rev    <= reverse;
                            r_issued <= '0;
                            r_busy   <= 1'b1;
                            r_state  <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (w_issue) begin
                        r_rd_data <= r_mem[r_addr];
                        r_addr    <= w_next_addr;
                        r_issued  <= r_issued + LW'(1);
                        if (w_final_issue)
                            r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_accept && r_last0) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase

            // r_buf0 is the head presented on out_data; r_buf1 only holds data when r_cnt == 2.
            if (r_rd_valid && w_accept) begin
                if (r_cnt == 2'd1) begin
                    r_buf0  <= r_rd_data;
                    r_last0 <= r_rd_last;
                end else begin
                    r_buf0  <= r_buf1;
                    r_last0 <= r_last1;
                    r_buf1  <= r_rd_data;
                    r_last1 <= r_rd_last;
                end
            end else if (r_rd_valid) begin
                if (r_cnt == 2'd0) begin
                    r_buf0  <= r_rd_data;
                    r_last0 <= r_rd_last;
                end else begin
                    r_buf1  <= r_rd_data;
                    r_last1 <= r_rd_last;
                end
                r_cnt <= r_cnt + 2'd1;
            end else if (w_accept) begin
                r_buf0  <= r_buf1;
                r_last0 <= (r_cnt == 2'd2) && r_last1;
                r_cnt   <= r_cnt - 2'd1;
            end
        end
    end

    assign out_data  = r_buf0;
    assign out_valid = (r_cnt != 2'd0);
    assign out_last  = r_last0;
    assign busy      = r_busy;
    assign done      = r_done;
    assign wr_err    = r_wr_err;

endmodule

// File: tb/tb_mod_word_mem.sv
// Directed bench for mod_word_mem: a memory model plus hand-computed values
// checked with immediate assertions at negedge sample points.
module tb_mod_word_mem;

    localparam int DW = 32;
    localparam int AW = 7;
    localparam int TA = 128;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_err;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   length;
    logic          reverse;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_last;
    logic          out_ready;
    logic          busy;
    logic          done;

    mod_word_mem #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .TOTAL_ADDR(TA)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .wr_err(wr_err),
        .start(start),
        .base_addr(base_addr),
        .length(length),
        .reverse(reverse),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_last(out_last),
        .out_ready(out_ready),
        .busy(busy),
        .done(done)
    );

    always #5 clock = ~clock;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [DW-1:0] m_mem [TA];
    logic [DW-1:0] q_data [$];
    logic          q_last [$];
    int            first_valid_c;
    int            last_acc_c;
    int            done_c;
    logic          done_busy;
    logic          got_done;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic write_word(input int a, input logic [DW-1:0] d);
        @(negedge clock);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
        m_mem[a] = d;
        @(posedge clock);
        #1 wr_en = 1'b0;
    endtask

    task automatic kick(input int base, input int len, input logic rev);
        @(negedge clock);
        start     = 1'b1;
        base_addr = AW'(base);
        length    = (AW + 1)'(len);
        reverse   = rev;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    // mode 1: random ready with a forced 5-cycle low run; inj_c: cycle to fire a write+start while busy
    task automatic collect(input int max_cyc, input int mode, input int inj_c);
        logic          prev_stall;
        logic [DW-1:0] prev_d;
        logic          prev_l;
        prev_stall = 1'b0;
        prev_d = '0;
        prev_l = 1'b0;
        q_data.delete();
        q_last.delete();
        first_valid_c = -1;
        last_acc_c    = -1;
        done_c        = -1;
        got_done      = 1'b0;
        done_busy     = 1'bx;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clock);
            if (mode == 1)
                out_ready = (c >= 3 && c <= 7) ? 1'b0 : 1'($urandom_range(0, 1));
            else
                out_ready = 1'b1;
            if (c == inj_c) begin
                wr_en = 1'b1; wr_addr = AW'(21); wr_data = 32'hDEADBEEF;
                start = 1'b1; base_addr = '0; length = (AW + 1)'(3); reverse = 1'b0;
            end else if (c == inj_c + 1) begin
                wr_en = 1'b0;
                start = 1'b0;
            end
            if (done) begin
                got_done  = 1'b1;
                done_c    = c;
                done_busy = busy;
                break;
            end
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, prev_d);
                chk("stall_last", out_last, prev_l);
            end
            if (out_valid && first_valid_c < 0)
                first_valid_c = c;
            if (out_valid && out_ready) begin
                q_data.push_back(out_data);
                q_last.push_back(out_last);
                last_acc_c = c;
            end
            prev_stall = out_valid && !out_ready;
            prev_d     = out_data;
            prev_l     = out_last;
        end
        wr_en = 1'b0;
        start = 1'b0;
    endtask

    task automatic check_stream(input string tag, input int base, input int len, input logic rev);
        int n;
        int a;
        n = (len > TA) ? TA : len;
        chk({tag, "_count"}, q_data.size(), n);
        chk({tag, "_done_seen"}, got_done, 1);
        chk({tag, "_busy_at_done"}, done_busy, 0);
        chk({tag, "_done_timing"}, done_c, last_acc_c + 1);
        for (int i = 0; i < q_data.size() && i < n; i++) begin
            a = rev ? (base + n - 1 - i) % TA : (base + i) % TA;
            chk({tag, "_data"}, q_data[i], m_mem[a]);
            chk({tag, "_last"}, q_last[i], (i == n - 1) ? 1 : 0);
        end
        @(negedge clock);
        chk({tag, "_done_one_cycle"}, done, 0);
        chk({tag, "_idle_valid"}, out_valid, 0);
    endtask

    initial begin
        reset_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; base_addr = '0; length = '0; reverse = 1'b0; out_ready = 1'b1;

        // reset state
        repeat (3) @(negedge clock);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_wr_err", wr_err, 0);
        chk("rst_data", out_data, 0);
        reset_n = 1'b1;

        // fill and full forward stream
        for (int i = 0; i < TA; i++)
            write_word(i, 32'hA500_0000 + 32'(i));
        chk("fill_wr_err", wr_err, 0);
        kick(0, 128, 1'b0);
        collect(400, 0, -10);
        chk("full_first_valid", first_valid_c, 2);
        chk("full_no_bubble", last_acc_c, 129);
        if (q_data.size() == 128) begin
            chk("full_first_word", q_data[0], 32'hA500_0000);
            chk("full_last_word", q_data[127], 32'hA500_007F);
        end
        check_stream("full", 0, 128, 1'b0);

        // reverse with wrap: addresses 1, 0, 127, 126
        kick(126, 4, 1'b1);
        collect(100, 0, -10);
        if (q_data.size() == 4) begin
            chk("rev_beat0", q_data[0], 32'hA500_0001);
            chk("rev_beat2", q_data[2], 32'hA500_007F);
            chk("rev_beat3", q_data[3], 32'hA500_007E);
        end
        check_stream("rev", 126, 4, 1'b1);

        // back-pressure
        kick(10, 8, 1'b0);
        collect(300, 1, -10);
        check_stream("stall", 10, 8, 1'b0);

        // oversize length clamps to the full depth, wrapping from 64
        kick(64, 200, 1'b0);
        collect(400, 0, -10);
        check_stream("clamp", 64, 200, 1'b0);

        // write and start while busy are both ignored
        kick(20, 6, 1'b0);
        collect(100, 0, 1);
        check_stream("busy", 20, 6, 1'b0);
        repeat (3) @(negedge clock);
        chk("busy_no_restart", out_valid, 0);
        chk("busy_idle", busy, 0);
        chk("wr_err_set", wr_err, 1);
        kick(21, 1, 1'b0);
        collect(50, 0, -10);
        if (q_data.size() == 1)
            chk("busy_addr21_kept", q_data[0], 32'hA500_0015);
        check_stream("readback21", 21, 1, 1'b0);
        chk("wr_err_sticky", wr_err, 1);

        // zero-length start
        kick(0, 0, 1'b0);
        @(negedge clock);
        chk("len0_done", done, 1);
        chk("len0_valid", out_valid, 0);
        chk("len0_busy", busy, 0);
        @(negedge clock);
        chk("len0_done_end", done, 0);
        chk("len0_valid_end", out_valid, 0);

        // same-cycle write and start
        @(negedge clock);
        wr_en = 1'b1; wr_addr = AW'(5); wr_data = 32'h1234_5678; m_mem[5] = 32'h1234_5678;
        start = 1'b1; base_addr = AW'(5); length = (AW + 1)'(1); reverse = 1'b0;
        @(posedge clock);
        #1 begin wr_en = 1'b0; start = 1'b0; end
        collect(50, 0, -10);
        if (q_data.size() == 1)
            chk("wr_start_word", q_data[0], 32'h1234_5678);
        check_stream("wr_start", 5, 1, 1'b0);

        // reset at beat 3 of a 16-beat stream
        kick(0, 16, 1'b0);
        out_ready = 1'b1;
        repeat (6) @(negedge clock);
        chk("pre_rst_valid", out_valid, 1);
        chk("pre_rst_beat3", out_data, 32'hA500_0003);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_data", out_data, 0);
        chk("arst_last", out_last, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_wr_err", wr_err, 0);
        repeat (3) begin
            @(negedge clock);
            chk("arst_hold_done", done, 0);
        end
        reset_n = 1'b1;
        repeat (2) begin
            @(negedge clock);
            chk("post_rst_done", done, 0);
            chk("post_rst_valid", out_valid, 0);
        end
        kick(0, 16, 1'b0);
        collect(100, 0, -10);
        check_stream("post_rst", 0, 16, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mod_word_mem.md
MOD_WORD_MEM -- requirements
Module: mod_word_mem

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 7, meaning word-address width.
REQ-003 SHALL have parameter TOTAL_ADDR, default 128, meaning depth in words (at most 2^ADDR_WIDTH).
REQ-004 SHALL have ports: clock in 1 (sole clock, rising edge); reset_n in 1 (asynchronous, active-low).
REQ-005 SHALL have ports: wr_en in 1; wr_addr in ADDR_WIDTH; wr_data in DATA_WIDTH; wr_err out 1 (sticky).
REQ-006 SHALL have ports: start in 1; base_addr in ADDR_WIDTH; length in ADDR_WIDTH+1 (words); reverse in 1 (1 = highest word first).
REQ-007 SHALL have ports: out_data out DATA_WIDTH; out_valid out 1; out_last out 1; out_ready in 1.
REQ-008 SHALL have ports: busy out 1; done out 1 (one-cycle pulse).

Function
REQ-009 SHALL hold TOTAL_ADDR x DATA_WIDTH single-port storage with a registered read (data one cycle after address); contents undefined at power-up and retained through reset.
REQ-010 SHALL write wr_data to wr_addr on the clock edge where wr_en=1 and busy=0.
REQ-011 SHALL ignore wr_en while busy=1, set wr_err, and leave memory unchanged; wr_err clears only on reset.
REQ-012 SHALL use FSM states IDLE, RUN, DRAIN, with busy=1 in RUN and DRAIN.
REQ-013 IDLE: start=1 with length>0 latches base_addr, length and reverse, then enters RUN.
REQ-014 IDLE: start=1 with length=0 stays in IDLE, pulses done in the next cycle and produces no beats.
REQ-015 SHALL ignore start while busy=1.
REQ-016 SHALL compute beat address i (0..length-1) as (base_addr+i) mod TOTAL_ADDR when reverse=0, or (base_addr+length-1-i) mod TOTAL_ADDR when reverse=1; wrap-around past TOTAL_ADDR-1 is legal.
REQ-017 SHALL clamp length above TOTAL_ADDR to TOTAL_ADDR.
REQ-018 RUN: SHALL issue at most one read per cycle, only when the 2-entry output buffer occupancy plus in-flight reads is below 2; no beat may be lost or duplicated under any out_ready pattern.
REQ-019 RUN moves to DRAIN once the final read is issued; DRAIN moves to IDLE in the cycle the beat with out_last=1 is accepted.
REQ-020 A beat is accepted on a clock edge where out_valid=1 and out_ready=1; out_data and out_last SHALL stay stable while out_valid=1 and out_ready=0.
REQ-021 out_last SHALL be 1 only on beat length-1.
REQ-022 done SHALL pulse for exactly one cycle immediately after the last-beat acceptance; busy SHALL be 0 in that same cycle.
REQ-023 Latency: with start sampled at edge 0 and out_ready held 1, out_valid SHALL first be high after edge 2; then one beat per cycle with no bubbles.
REQ-024 A write and a start in the same IDLE cycle: the write SHALL complete first, and the stream SHALL return the newly written data.

Reset
REQ-025 While reset_n=0, the block SHALL force FSM=IDLE, buffer empty, in-flight reads discarded, and busy, done, out_valid, out_last and wr_err all 0, with out_data=0.
REQ-026 Reset asserted mid-stream SHALL abort the stream with no further beats and no done pulse; memory contents are preserved.

Verification
REQ-027 Write words 0..127 with value 0xA5000000+addr; stream with base=0, length=128, reverse=0, ready=1 -> 128 beats in order, first valid after edge 2, out_last on 0xA500007F, done pulse one cycle later.
REQ-028 Stream with base=126, length=4, reverse=1 -> beats in address order 1, 0, 127, 126; out_last on address 126.
REQ-029 Stream with length=8 while toggling out_ready randomly (including 5 consecutive low cycles) -> exactly 8 beats in order, no duplicates, data stable while stalled.
REQ-030 wr_en=1 while busy -> target address unchanged on a later read, wr_err=1 until reset; start while busy ignored, current stream unaffected.
REQ-031 Start with length=0 -> done pulse, no out_valid; same-cycle write to addr 5 (0x12345678) plus start with base=5, length=1 -> single beat 0x12345678.
REQ-032 reset_n low at beat 3 of a 16-beat stream -> all outputs 0 asynchronously, no done pulse; a subsequent stream returns the pre-reset memory data.
